// File: rtl/pc_gen.sv
// Fetch-stage program counter: sequential PC+INC issue with a valid/ready handshake,
// prioritised redirects and a one-deep redirect buffer. Optional feature: MISALIGN_TRAP_EN.
module pc_gen #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      NUM_SRC      = 4,
  parameter int unsigned      INC          = 4,
  parameter int unsigned      ALIGN_BITS   = 2,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'('h100)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     stall_i,
  input  logic                     fetch_rdy_i,
  input  logic [NUM_SRC-1:0]       redir_valid_i,
  input  logic [NUM_SRC*WIDTH-1:0] redir_target_i,
  output logic [WIDTH-1:0]         fetch_addr_o,
  output logic                     fetch_valid_c_o,
  output logic [WIDTH-1:0]         pc_next_c_o,
  output logic [NUM_SRC-1:0]       redir_taken_o,
  output logic                     pending_o,
  output logic                     misalign_o
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     pc_q, pc_d;
  logic [WIDTH-1:0]     pend_tgt_q, pend_tgt_d;
  logic [NUM_SRC-1:0]   taken_q, taken_d;
  logic                 mis_q, mis_d;
  logic                 pending_q, pending_d;

  logic [NUM_SRC-1:0]   sel_oh;
  logic [WIDTH-1:0]     sel_tgt;
  logic [WIDTH-1:0]     eff_tgt;
  logic                 tgt_mis;
  logic                 accept;

  assign fetch_valid_c_o = (state_q != BOOT) && !stall_i;
  assign accept          = fetch_valid_c_o && fetch_rdy_i;

  // Lowest set index wins; downward scan lets lower indices override.
  always_comb begin
    sel_oh  = '0;
    sel_tgt = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (redir_valid_i[i]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_tgt   = redir_target_i[i*WIDTH +: WIDTH];
      end
    end
  end

  // Misaligned targets either trap or get their low bits cleared.
  always_comb begin
    eff_tgt = sel_tgt;
    tgt_mis = 1'b0;
    if (TRAP_EN) begin
      if ((sel_tgt & ALIGN_MASK) != '0) begin
        eff_tgt = TRAP_VECTOR;
        tgt_mis = 1'b1;
      end
    end else begin
      eff_tgt = sel_tgt & ~ALIGN_MASK;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    taken_d    = '0;
    mis_d      = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN, HOLD: begin
        if (|redir_valid_i) begin
          taken_d = sel_oh;
          mis_d   = tgt_mis;
          if (accept || !fetch_valid_c_o) begin
            pc_d       = eff_tgt;
            pend_tgt_d = '0;
            state_d    = RUN;
          end else begin
            pend_tgt_d = eff_tgt;
            state_d    = HOLD;
          end
        end else if (accept) begin
          if (state_q == HOLD) begin
            pc_d       = pend_tgt_q;
            pend_tgt_d = '0;
            state_d    = RUN;
          end else begin
            pc_d = pc_q + INC_W;
          end
        end
      end
      default: state_d = BOOT;
    endcase
    pending_d = (state_d == HOLD);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      pend_tgt_q <= '0;
      taken_q    <= '0;
      mis_q      <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      taken_q    <= taken_d;
      mis_q      <= mis_d;
      pending_q  <= pending_d;
    end
  end

  assign pc_next_c_o   = rst_i ? RESET_VECTOR : pc_d;
  assign fetch_addr_o  = pc_q;
  assign redir_taken_o = taken_q;
  assign pending_o     = pending_q;
  assign misalign_o    = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed sequence then random traffic against a
// behavioural fetch-address model; a monitor compares every cycle.
module tb_pc_gen;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         stall = 1'b0;
  logic         rdy = 1'b0;
  logic [3:0]   rv = '0;
  logic [127:0] tgt = '0;
  logic [31:0]  fetch_addr;
  logic         fetch_valid;
  logic [31:0]  pc_next;
  logic [3:0]   taken;
  logic         pending;
  logic         misalign;

  logic [31:0]  tg [4];

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  bit done   = 1'b0;

  typedef struct {
    logic        fv;
    logic [31:0] pcn;
    logic [31:0] pc;
    logic        pend;
    logic [3:0]  taken;
    logic        mis;
  } exp_t;

  exp_t q[$];

  // Reference model state
  bit          m_run  = 1'b0;
  logic [31:0] m_pc   = 32'h0;
  bit          m_pend = 1'b0;
  logic [31:0] m_ptgt = 32'h0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .stall_i        (stall),
    .fetch_rdy_i    (rdy),
    .redir_valid_i  (rv),
    .redir_target_i (tgt),
    .fetch_addr_o   (fetch_addr),
    .fetch_valid_c_o(fetch_valid),
    .pc_next_c_o    (pc_next),
    .redir_taken_o  (taken),
    .pending_o      (pending),
    .misalign_o     (misalign)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, queue its expectation.
  task automatic step(input bit r, input bit s, input bit y, input logic [3:0] v);
    exp_t        e;
    logic [3:0]  oh;
    logic [31:0] t;
    bit          fv, acc;
    int          idx;
    @(negedge clk);
    rst = r; stall = s; rdy = y; rv = v;
    for (int i = 0; i < 4; i++) tgt[i*32 +: 32] = tg[i];
    fv      = m_run && !s;
    acc     = fv && y;
    e.fv    = fv;
    e.taken = '0;
    e.mis   = 1'b0;
    if (r) begin
      m_run = 1'b0; m_pc = 32'h0; m_pend = 1'b0; m_ptgt = 32'h0;
    end else if (!m_run) begin
      m_run = 1'b1;
    end else if (v != 4'd0) begin
      oh  = v & (~v + 4'd1);
      idx = $clog2(oh);
      t   = tg[idx];
`ifdef MISALIGN_TRAP_EN
      if (t % 4 != 0) begin
        t     = 32'h100;
        e.mis = 1'b1;
      end
`else
      t = t - (t % 4);
`endif
      e.taken = oh;
      if (acc || !fv) begin
        m_pc = t; m_pend = 1'b0;
      end else begin
        m_pend = 1'b1; m_ptgt = t;
      end
    end else if (acc) begin
      if (m_pend) begin
        m_pc = m_ptgt; m_pend = 1'b0;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
    e.pc   = m_pc;
    e.pcn  = m_pc;
    e.pend = m_pend;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: combinational outputs late in the low phase, registered after the edge.
  initial begin
    exp_t        e;
    logic        s_fv;
    logic [31:0] s_pcn;
    wait (mon_en);
    forever begin
      @(negedge clk);
      #3;
      s_fv  = fetch_valid;
      s_pcn = pc_next;
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        if (!done) chk("sb_no_expectation", 32'd0, 32'd1);
      end else begin
        e = q.pop_front();
        chk("sb_fetch_valid", 32'(s_fv), 32'(e.fv));
        chk("sb_pc_next", s_pcn, e.pcn);
        chk("sb_fetch_addr", fetch_addr, e.pc);
        chk("sb_pending", 32'(pending), 32'(e.pend));
        chk("sb_taken", 32'(taken), 32'(e.taken));
        chk("sb_misalign", 32'(misalign), 32'(e.mis));
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) tg[i] = 32'h0;
    #1 mon_en = 1'b1;

    // Reset, boot, sequential fetch
    step(1, 0, 1, 4'b0000);
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_addr", fetch_addr, 32'h0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_taken", 32'(taken), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    step(0, 0, 1, 4'b0000);
    chk("boot_valid", 32'(fetch_valid), 32'd1);
    chk("boot_addr", fetch_addr, 32'h0);
    step(0, 0, 1, 4'b0000);
    chk("seq_addr4", fetch_addr, 32'h4);
    step(0, 0, 1, 4'b0000);
    chk("seq_addr8", fetch_addr, 32'h8);

    // Stall holds the address
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 1, 4'b0000);
      chk("stall_valid", 32'(fetch_valid), 32'd0);
      chk("stall_addr", fetch_addr, 32'h8);
    end
    step(0, 0, 1, 4'b0000);
    chk("unstall_addr", fetch_addr, 32'hC);

    // Redirect during a blocked handshake is buffered
    tg[1] = 32'h200;
    step(0, 0, 0, 4'b0010);
    chk("buf_pending", 32'(pending), 32'd1);
    chk("buf_addr", fetch_addr, 32'hC);
    chk("buf_taken", 32'(taken), 32'h2);
    step(0, 0, 1, 4'b0000);
    chk("buf_release_addr", fetch_addr, 32'h200);
    chk("buf_release_pending", 32'(pending), 32'd0);
    chk("buf_taken_pulse", 32'(taken), 32'd0);

    // Simultaneous redirects: lowest index only
    tg[1] = 32'h40; tg[2] = 32'h80;
    step(0, 0, 1, 4'b0110);
    chk("prio_addr", fetch_addr, 32'h40);
    chk("prio_taken", 32'(taken), 32'h2);

    // Wraparound
    tg[0] = 32'hFFFF_FFFC;
    step(0, 0, 1, 4'b0001);
    chk("wrap_pre", fetch_addr, 32'hFFFF_FFFC);
    step(0, 0, 1, 4'b0000);
    chk("wrap_addr", fetch_addr, 32'h0);

    // Newer redirect overwrites pending
    tg[3] = 32'h500; tg[2] = 32'h600;
    step(0, 0, 0, 4'b1000);
    step(0, 0, 0, 4'b0100);
    step(0, 0, 1, 4'b0000);
    chk("overwrite_addr", fetch_addr, 32'h600);

    // Redirect with accept in HOLD drops pending
    tg[0] = 32'h700; tg[1] = 32'h800;
    step(0, 0, 0, 4'b0001);
    step(0, 0, 1, 4'b0010);
    chk("drop_addr", fetch_addr, 32'h800);
    chk("drop_pending", 32'(pending), 32'd0);
    step(0, 0, 1, 4'b0000);
    chk("drop_next", fetch_addr, 32'h804);

    // Reset while holding a buffered redirect
    tg[0] = 32'h300;
    step(0, 0, 0, 4'b0001);
    chk("hold_pending", 32'(pending), 32'd1);
    step(1, 0, 0, 4'b0001);
    chk("rst_hold_addr", fetch_addr, 32'h0);
    chk("rst_hold_pending", 32'(pending), 32'd0);
    step(0, 0, 1, 4'b0000);

    // Misaligned target
    tg[2] = 32'h202;
    step(0, 0, 1, 4'b0100);
`ifdef MISALIGN_TRAP_EN
    chk("mis_addr", fetch_addr, 32'h100);
    chk("mis_pulse", 32'(misalign), 32'd1);
`else
    chk("mis_addr", fetch_addr, 32'h200);
    chk("mis_pulse", 32'(misalign), 32'd0);
`endif
    step(0, 0, 1, 4'b0000);
    chk("mis_pulse_end", 32'(misalign), 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 3))
          0: tg[i] = $urandom & ~32'd3;
          1: tg[i] = $urandom;
          2: tg[i] = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
          default: tg[i] = 32'h1000 + 32'(4 * $urandom_range(0, 15));
        endcase
      end
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15)));
    end

    done = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) chk("sb_leftover", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
